fetch_unit: RTL and testbench

//  Instruction fetch stage directly upstream of the main control decoder.
//  - Holds the PC and fetches one 32-bit word per instruction over a req/valid memory handshake.
//  - Latches the word into an instruction register and presents opCode[5:0] to the control decoder.
//  - Picks the next PC from the decoder's jump/branch outputs and the ALU zero flag.

---
 rtl/fetch_unit.sv | 81 ++++++++
 tb/tb_fetch_unit.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: PC register, instruction fetch handshake and next-PC selection
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             imemReq,
  output logic [31:0]      imemAddr,
  input  logic             imemValid,
  input  logic [31:0]      imemData,
  input  logic             stall,
  input  logic             jump,
  input  logic             branch,
  input  logic             zero,
  output logic [31:0]      instr,
  output logic [5:0]       opCode,
  output logic             instrValid,
  output logic [31:0]      pc,
  output logic [31:0]      pcPlus4,
  output logic             fetchErr,
  output logic [CNT_W-1:0] retireCnt
);
  typedef enum logic [1:0] {FETCH, HOLD, ERR} state_t;
  state_t             state_q, state_d;
  logic [31:0]        pc_q, pc_d, instr_q, instr_d, next_pc;
  logic               valid_q, valid_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  assign pcPlus4    = pc_q + 32'd4;
  assign imemReq    = rst_n && state_q == FETCH;
  assign imemAddr   = pc_q;
  assign instr      = instr_q;
  assign opCode     = instr_q[31:26];
  assign instrValid = valid_q;
  assign pc         = pc_q;
  assign fetchErr   = state_q == ERR;
  assign retireCnt  = cnt_q;
  // Next PC: jump beats a taken branch, otherwise fall through
  always_comb
    next_pc = jump ? {pcPlus4[31:28], instr_q[25:0], 2'b00}
            : (branch & zero) ? pcPlus4 + {{14{instr_q[15]}}, instr_q[15:0], 2'b00}
            : pcPlus4;
  // FSM next state: capture on imemValid in FETCH, advance or trap when unstalled in HOLD
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    if (state_q == FETCH && imemValid) begin
      instr_d = imemData;
      valid_d = 1'b1;
      state_d = HOLD;
    end else if (state_q == HOLD && !stall) begin
      valid_d = 1'b0;
      if (next_pc[1:0] != 2'b00) begin
        state_d = ERR;
      end else begin
        pc_d    = next_pc;
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = FETCH;
      end
    end
  end
  // State registers with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch_unit with three reset-PC builds
module tb_fetch_unit;
  logic clk = 1'b0, rst_n = 1'b0;
  logic imemValid = 1'b0, stall = 1'b0, jump = 1'b0, branch = 1'b0, zero = 1'b0;
  logic [31:0] imemData = '0;
  logic req, req_j, req_e, iv, iv_j, iv_e, err, err_j, err_e;
  logic [31:0] addr, addr_j, addr_e, ins, ins_j, ins_e, pcv, pc_j, pc_e, p4, p4_j, p4_e;
  logic [5:0] op, op_j, op_e;
  logic [15:0] cnt, cnt_j, cnt_e;
  int vectors = 0, miscompares = 0;

  always #5 clk = ~clk;

  fetch_unit dut (.clk(clk), .rst_n(rst_n), .imemReq(req), .imemAddr(addr), .imemValid(imemValid),
    .imemData(imemData), .stall(stall), .jump(jump), .branch(branch), .zero(zero), .instr(ins),
    .opCode(op), .instrValid(iv), .pc(pcv), .pcPlus4(p4), .fetchErr(err), .retireCnt(cnt));
  fetch_unit #(.RESET_PC(32'h1000_0010)) dut_j (.clk(clk), .rst_n(rst_n), .imemReq(req_j),
    .imemAddr(addr_j), .imemValid(imemValid), .imemData(imemData), .stall(stall), .jump(jump),
    .branch(branch), .zero(zero), .instr(ins_j), .opCode(op_j), .instrValid(iv_j), .pc(pc_j),
    .pcPlus4(p4_j), .fetchErr(err_j), .retireCnt(cnt_j));
  fetch_unit #(.RESET_PC(32'h0000_0002)) dut_e (.clk(clk), .rst_n(rst_n), .imemReq(req_e),
    .imemAddr(addr_e), .imemValid(imemValid), .imemData(imemData), .stall(stall), .jump(jump),
    .branch(branch), .zero(zero), .instr(ins_e), .opCode(op_e), .instrValid(iv_e), .pc(pc_e),
    .pcPlus4(p4_e), .fetchErr(err_e), .retireCnt(cnt_e));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask

  task automatic fetch_adv(input logic [31:0] d, input logic j, input logic b, input logic z);
    imemValid = 1'b1;
    imemData  = d;
    step();
    imemValid = 1'b0;
    jump = j; branch = b; zero = z;
    step();
    jump = 1'b0; branch = 1'b0; zero = 1'b0;
  endtask

  task automatic test_reset();
    step(); step();
    vectors++; if (pcv !== 32'h0) begin miscompares++; $display("FAIL rst_pc got %h exp %h", pcv, 32'h0); end
    vectors++; if (ins !== 32'h0) begin miscompares++; $display("FAIL rst_instr got %h exp %h", ins, 32'h0); end
    vectors++; if (iv !== 1'b0) begin miscompares++; $display("FAIL rst_valid got %b exp 0", iv); end
    vectors++; if (req !== 1'b0) begin miscompares++; $display("FAIL rst_req got %b exp 0", req); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL rst_err got %b exp 0", err); end
    vectors++; if (cnt !== 16'h0) begin miscompares++; $display("FAIL rst_cnt got %h exp 0", cnt); end
    rst_n = 1'b1;
    #1;
    vectors++; if (req !== 1'b1) begin miscompares++; $display("FAIL rel_req got %b exp 1", req); end
    vectors++; if (addr !== 32'h0) begin miscompares++; $display("FAIL rel_addr got %h exp 0", addr); end
  endtask

  task automatic test_zero_latency();
    imemValid = 1'b1;
    imemData  = 32'h2008_0005;
    step();
    vectors++; if (iv !== 1'b1) begin miscompares++; $display("FAIL zl_valid got %b exp 1", iv); end
    vectors++; if (op !== 6'b001000) begin miscompares++; $display("FAIL zl_opcode got %b exp 001000", op); end
    vectors++; if (ins !== 32'h2008_0005) begin miscompares++; $display("FAIL zl_instr got %h exp 20080005", ins); end
    vectors++; if (req !== 1'b0) begin miscompares++; $display("FAIL zl_hold_req got %b exp 0", req); end
    imemValid = 1'b0;
    step();
    vectors++; if (addr !== 32'h4) begin miscompares++; $display("FAIL zl_next_addr got %h exp 4", addr); end
    vectors++; if (cnt !== 16'd1) begin miscompares++; $display("FAIL zl_cnt got %0d exp 1", cnt); end
    vectors++; if (iv !== 1'b0 || req !== 1'b1) begin miscompares++; $display("FAIL zl_refetch got valid=%b req=%b exp 0/1", iv, req); end
  endtask

  task automatic test_latency();
    imemValid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++; if (addr !== 32'h4 || req !== 1'b1 || iv !== 1'b0) begin
        miscompares++; $display("FAIL lat_wait%0d got addr=%h req=%b valid=%b exp 4/1/0", i, addr, req, iv);
      end
    end
    imemValid = 1'b1;
    imemData  = 32'h0;
    step();
    vectors++; if (iv !== 1'b1 || cnt !== 16'd1) begin miscompares++; $display("FAIL lat_capture got valid=%b cnt=%0d exp 1/1", iv, cnt); end
    imemValid = 1'b0;
    step();
    vectors++; if (addr !== 32'h8 || cnt !== 16'd2) begin miscompares++; $display("FAIL lat_adv got addr=%h cnt=%0d exp 8/2", addr, cnt); end
  endtask

  task automatic test_branch();
    fetch_adv(32'h0800_0010, 1'b1, 1'b0, 1'b0);
    vectors++; if (addr !== 32'h40) begin miscompares++; $display("FAIL br_jump_to_40 got %h exp 40", addr); end
    fetch_adv(32'h1000_FFFF, 1'b0, 1'b1, 1'b1);
    vectors++; if (addr !== 32'h40) begin miscompares++; $display("FAIL br_taken got %h exp 40", addr); end
    fetch_adv(32'h1000_FFFF, 1'b0, 1'b1, 1'b0);
    vectors++; if (addr !== 32'h44) begin miscompares++; $display("FAIL br_not_taken got %h exp 44", addr); end
    vectors++; if (cnt !== 16'd5) begin miscompares++; $display("FAIL br_cnt got %0d exp 5", cnt); end
  endtask

  task automatic test_stall();
    imemValid = 1'b1;
    imemData  = 32'hAC00_0000;
    step();
    stall = 1'b1;
    imemData = 32'hFFFF_FFFF;
    for (int i = 0; i < 5; i++) begin
      step();
      vectors++; if (pcv !== 32'h44 || ins !== 32'hAC00_0000 || cnt !== 16'd5 || req !== 1'b0 || iv !== 1'b1) begin
        miscompares++; $display("FAIL stall%0d got pc=%h instr=%h cnt=%0d req=%b valid=%b exp 44/ac000000/5/0/1", i, pcv, ins, cnt, req, iv);
      end
    end
    stall = 1'b0;
    imemValid = 1'b0;
    step();
    vectors++; if (addr !== 32'h48 || cnt !== 16'd6) begin miscompares++; $display("FAIL stall_release got addr=%h cnt=%0d exp 48/6", addr, cnt); end
  endtask

  task automatic test_jump();
    pulse_reset();
    fetch_adv(32'h0800_0100, 1'b1, 1'b0, 1'b0);
    vectors++; if (addr_j !== 32'h1000_0400) begin miscompares++; $display("FAIL j_target got %h exp 10000400", addr_j); end
    vectors++; if (addr !== 32'h0000_0400) begin miscompares++; $display("FAIL j_target_low got %h exp 00000400", addr); end
    pulse_reset();
    fetch_adv(32'h0800_0100, 1'b1, 1'b1, 1'b1);
    vectors++; if (addr_j !== 32'h1000_0400) begin miscompares++; $display("FAIL j_priority got %h exp 10000400", addr_j); end
  endtask

  task automatic test_async_reset();
    pulse_reset();
    fetch_adv(32'h0, 1'b0, 1'b0, 1'b0);
    step();
    rst_n = 1'b0;
    #1;
    vectors++; if (addr !== 32'h0 || req !== 1'b0 || cnt !== 16'd0) begin
      miscompares++; $display("FAIL arst_fetch got addr=%h req=%b cnt=%0d exp 0/0/0", addr, req, cnt);
    end
    rst_n = 1'b1;
    fetch_adv(32'h0, 1'b0, 1'b0, 1'b0);
    imemValid = 1'b1;
    imemData  = 32'h2008_0005;
    step();
    stall = 1'b1;
    imemValid = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    vectors++; if (iv !== 1'b0 || ins !== 32'h0 || pcv !== 32'h0) begin
      miscompares++; $display("FAIL arst_hold got valid=%b instr=%h pc=%h exp 0/0/0", iv, ins, pcv);
    end
    rst_n = 1'b1;
    stall = 1'b0;
  endtask

  task automatic test_err();
    step();
    pulse_reset();
    fetch_adv(32'h0, 1'b0, 1'b0, 1'b0);
    vectors++; if (err_e !== 1'b1 || req_e !== 1'b0 || iv_e !== 1'b0 || pc_e !== 32'h2) begin
      miscompares++; $display("FAIL err_enter got err=%b req=%b valid=%b pc=%h exp 1/0/0/2", err_e, req_e, iv_e, pc_e);
    end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL err_aligned got %b exp 0", err); end
    imemValid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++; if (err_e !== 1'b1 || req_e !== 1'b0 || iv_e !== 1'b0) begin
        miscompares++; $display("FAIL err_sticky%0d got err=%b req=%b valid=%b exp 1/0/0", i, err_e, req_e, iv_e);
      end
    end
    imemValid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_zero_latency();
    test_latency();
    test_branch();
    test_stall();
    test_jump();
    test_async_reset();
    test_err();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
